// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix lines toward the keypad plus the
// decoded key/entry outputs toward the calculator datapath.
interface keypad_scanner_if;
    logic [3:0]  row_i;       // keypad rows, active-low, asynchronous to clk
    logic [3:0]  col_select;  // column drive, one-hot active-low
    logic        key_valid;   // one-cycle strobe per accepted press
    logic [3:0]  key_code;    // last accepted key, held after the strobe
    logic [13:0] number_o;    // decimal entry value, 0..9999

    // Scanner side: samples rows, drives columns and results.
    modport master (
        input  row_i,
        output col_select,
        output key_valid,
        output key_code,
        output number_o
    );

    // Keypad / consumer side.
    modport slave (
        output row_i,
        input  col_select,
        input  key_valid,
        input  key_code,
        input  number_o
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column select, debounces
// presses and releases on synchronized rows, strobes each accepted key once
// and accumulates digit keys into a decimal entry value (0..9999).
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 2**16 - 1,  // cycles per column minus 1 (>= 4)
    parameter int unsigned DEBOUNCE_CYCLES = 2**20 - 1   // stable cycles minus 1 to accept
) (
    input  logic             clk,
    input  logic             reset_n,
    keypad_scanner_if.master kp
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        lat_row_q, lat_row_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_code_q, key_code_d;
    logic [13:0]       number_q;

    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic              win_valid;
    logic [1:0]        win_row;

    // Map (row, column) to the calculator key code.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= kp.row_i;
            row_sync <= row_meta;
        end
    end

    // Priority encode the synchronized rows: lowest low row wins.
    always_comb begin
        win_valid = ~&row_sync;
        win_row   = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) win_row = 2'(r);
        end
    end

    // Scan/debounce FSM: next state and next register values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        col_d       = col_q;
        lat_row_d   = lat_row_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_MAX) begin
                    if (win_valid) begin
                        // Column stays put; it is the latched column.
                        lat_row_d = win_row;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d      = col_q + 2'd1;
                        scan_cnt_d = '0;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (win_valid && (win_row == lat_row_q)) begin
                    if (deb_cnt_q == DEB_MAX) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_map(lat_row_q, col_q);
                        state_d     = HELD;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    // Bounce or glitch: rescan the same column from scratch.
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end
            end

            HELD: begin
                if (&row_sync) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASE;
                end
            end

            RELEASE: begin
                if (win_valid) begin
                    // Release bounce: back to waiting, no new strobe.
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_MAX) begin
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = SCAN;
                scan_cnt_d = '0;
            end
        endcase
    end

    // FSM state, counters and key outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            col_q       <= 2'd0;
            lat_row_q   <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            col_q       <= col_d;
            lat_row_q   <= lat_row_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    // Decimal entry accumulator, updated the edge after each strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            number_q <= 14'd0;
        end else if (key_valid_q) begin
            if (key_code_q == KEY_CLEAR) begin
                number_q <= 14'd0;
            end else if ((key_code_q <= 4'd9) && (number_q <= 14'd999)) begin
                // n*10 + d as shifts; n <= 999 keeps the result within 9999.
                number_q <= (number_q << 3) + (number_q << 1) + {10'd0, key_code_q};
            end
        end
    end

    assign kp.col_select = ~(4'b0001 << col_q);
    assign kp.key_valid  = key_valid_q;
    assign kp.key_code   = key_code_q;
    assign kp.number_o   = number_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the
// rows from the pressed-key set and the column select; a table key map and
// an arithmetic entry model provide every expected value.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 7;
    localparam int DEB      = 15;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] pressed = 16'h0;  // bit r*4+c set while key (r,c) is down

    int tests_run    = 0;
    int tests_failed = 0;
    int strobes      = 0;
    int model_num    = 0;

    logic [3:0] key_tab [16];

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kif.master)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits on the driven column.
    function automatic logic [3:0] rows_of(input logic [15:0] p, input logic [3:0] cs);
        logic [3:0] rw;
        rw = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (p[r*4+c] && !cs[c]) rw[r] = 1'b0;
        return rw;
    endfunction

    assign kif.row_i = rows_of(pressed, kif.col_select);

    // Count every strobe cycle seen outside reset.
    always @(negedge clk) begin
        if (reset_n && kif.key_valid === 1'b1) strobes++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_key(input logic [3:0] code);
        if (code == 4'hC) model_num = 0;
        else if (code <= 4'd9 && model_num <= 999) model_num = model_num * 10 + int'(code);
    endtask

    task automatic wait_strobe(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) found = 1'b1;
        end
        check({tag, "_strobe_seen"}, 32'(found), 32'd1);
    endtask

    // After a strobe: code check, one-cycle pulse, entry update next cycle.
    task automatic check_strobe(input string tag, input int r, input int c);
        logic [3:0] exp_code;
        exp_code = key_tab[r*4+c];
        check({tag, "_code"}, 32'(kif.key_code), 32'(exp_code));
        model_key(exp_code);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(kif.key_valid), 32'd0);
        check({tag, "_number"}, 32'(kif.number_o), 32'(model_num));
    endtask

    task automatic press_key(input string tag, input int r, input int c, input int hold);
        int  s0;
        bit  found;
        s0 = strobes;
        pressed[r*4+c] = 1'b1;
        wait_strobe(tag, found);
        if (found) check_strobe(tag, r, c);
        repeat (hold) @(negedge clk);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        check({tag, "_one_strobe"}, 32'(strobes - s0), 32'd1);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] want);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (kif.col_select === want) found = 1'b1;
        end
        check({tag, "_col_reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        bit found;
        int s0;
        key_tab = '{4'h1, 4'h2, 4'h3, 4'hA,
                    4'h4, 4'h5, 4'h6, 4'hB,
                    4'h7, 4'h8, 4'h9, 4'hC,
                    4'hE, 4'h0, 4'hF, 4'hD};

        // 1. Reset values and the column rotation timing.
        #1 reset_n = 1'b0;
        #1;
        check("rst_col", 32'(kif.col_select), 32'hE);
        check("rst_valid", 32'(kif.key_valid), 32'd0);
        check("rst_code", 32'(kif.key_code), 32'd0);
        check("rst_number", 32'(kif.number_o), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check($sformatf("rot_k%0d", k), 32'(kif.col_select),
                  32'(~(4'b0001 << ((k / (SCAN_DIV + 1)) % 4)) & 4'hF));
        end

        // 2. Key 5 held 40 cycles: one strobe, then scanning resumes at 1011.
        s0 = strobes;
        pressed[1*4+1] = 1'b1;
        wait_strobe("k5", found);
        if (found) check_strobe("k5", 1, 1);
        repeat (38) @(negedge clk);
        pressed = 16'h0;
        repeat (5) @(negedge clk);
        check("k5_col_held", 32'(kif.col_select), 32'hD);
        wait_col("k5_resume", 4'b1011);
        check("k5_one_strobe", 32'(strobes - s0), 32'd1);

        // 3. Clear, then 1,2,3,4 accumulate; the fifth digit is ignored.
        press_key("clr", 2, 3, 2);
        press_key("d1", 0, 0, 3);
        press_key("d2", 0, 1, 0);
        press_key("d3", 0, 2, 10);
        press_key("d4", 1, 0, 5);
        press_key("d5", 1, 1, 5);
        check("entry_1234", 32'(kif.number_o), 32'd1234);

        // 4. Bouncing key 9: only one strobe across press and release bounce.
        wait_col("b9_sync", 4'b1011);
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            pressed[2*4+2] = 1'b1;
            repeat (3) @(negedge clk);
            pressed[2*4+2] = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("b9_no_early", 32'(strobes - s0), 32'd0);
        pressed[2*4+2] = 1'b1;
        wait_strobe("b9", found);
        if (found) check_strobe("b9", 2, 2);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pressed[2*4+2] = 1'b0;
            repeat (3) @(negedge clk);
            pressed[2*4+2] = 1'b1;
            repeat (3) @(negedge clk);
        end
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        check("b9_one_strobe", 32'(strobes - s0), 32'd1);

        // 5. Clear key zeroes the entry; letter keys leave it alone.
        press_key("kc", 2, 3, 4);
        check("kc_zero", 32'(kif.number_o), 32'd0);
        press_key("k7", 2, 0, 4);
        press_key("ka", 0, 3, 4);
        check("ka_keeps", 32'(kif.number_o), 32'd7);

        // 6. Rows 0 and 2 low on column 0: row 0 wins; reset from HELD.
        pressed[0*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        wait_strobe("prio", found);
        if (found) check_strobe("prio", 0, 0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_num = 0;
        check("hrst_col", 32'(kif.col_select), 32'hE);
        check("hrst_valid", 32'(kif.key_valid), 32'd0);
        check("hrst_code", 32'(kif.key_code), 32'd0);
        check("hrst_number", 32'(kif.number_o), 32'd0);
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (SCAN_DIV) @(negedge clk);
        check("hrst_col_k7", 32'(kif.col_select), 32'hE);
        @(negedge clk);
        check("hrst_col_k8", 32'(kif.col_select), 32'hD);

        // Randomized key sequence against the table and entry model.
        for (int n = 0; n < 16; n++) begin
            int r, c;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            press_key($sformatf("rnd%0d_r%0dc%0d", n, r, c), r, c, int'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
